// File: rtl/pi_sched_if.sv
// rtl/pi_sched_if.sv - request/result bus of the shared PI controller scheduler
interface pi_sched_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]      i_req;
    logic [32*N_CH-1:0]   i_err;
    logic [N_CH-1:0]      i_clr;
    logic [N_CH-1:0]      o_ack;
    logic                 o_valid;
    logic [CH_W-1:0]      o_ch;
    logic signed [31:0]   o_u;
    logic                 o_sat;
    logic                 o_busy;

    modport master (
        output i_req, i_err, i_clr,
        input  o_ack, o_valid, o_ch, o_u, o_sat, o_busy
    );

    modport slave (
        input  i_req, i_err, i_clr,
        output o_ack, o_valid, o_ch, o_u, o_sat, o_busy
    );
endinterface

// File: rtl/pi_sched.sv
// rtl/pi_sched.sv - round-robin PI controller sharing one MAC across N_CH loops
// Optional conditional-integration anti-windup: define PI_SCHED_AW_EN.
module pi_sched #(
    parameter int                 N_CH = 4,
    parameter int signed          KP   = 1,
    parameter int signed          TSKI = 0,
    parameter logic signed [31:0] U_MAX = 100,
    parameter logic signed [31:0] U_MIN = 0
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    pi_sched_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic signed [63:0] KP64    = 64'(KP);
    localparam logic signed [63:0] TSKI64  = 64'(TSKI);
    localparam logic signed [63:0] UMAX64  = 64'(U_MAX);
    localparam logic signed [63:0] UMIN64  = 64'(U_MIN);
    localparam logic signed [32:0] INT_POS = 33'sd2147483647;
    localparam logic signed [32:0] INT_NEG = -33'sd2147483647;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_P,
        S_MUL_I,
        S_SAT,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]    ch_q;
    logic [CH_W-1:0]    last_q;
    logic [CH_W-1:0]    grant_ch;
    logic [CH_W-1:0]    cand;
    logic               grant_vld;
    logic signed [31:0] err_q;
    logic signed [31:0] int_new_q;
    logic signed [31:0] u_q;
    logic signed [63:0] p_q;
    logic signed [63:0] acc_q;
    logic               sat_hi_q;
    logic               sat_lo_q;
    logic signed [31:0] integ_q [N_CH];
    logic signed [31:0] err_arr [N_CH];
    logic signed [32:0] int_sum;
    logic signed [31:0] int_sat;
    logic               hold;
    logic               wr_en;

    for (genvar k = 0; k < N_CH; k++) begin : g_err
        assign err_arr[k] = bus.i_err[32*k +: 32];
    end

    // Walk from farthest to nearest so the channel right after last_q wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = CH_W'((int'(last_q) + i) % N_CH);
            if (bus.i_req[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    always_comb begin
        int_sum = 33'(integ_q[ch_q]) + 33'(err_q);
        if (int_sum > INT_POS) begin
            int_sat = 32'sh7FFF_FFFF;
        end else if (int_sum < INT_NEG) begin
            int_sat = 32'sh8000_0001;
        end else begin
            int_sat = int_sum[31:0];
        end
    end

`ifdef PI_SCHED_AW_EN
    assign hold = (sat_hi_q && (err_q > 0)) || (sat_lo_q && (err_q < 0));
`else
    assign hold = 1'b0;
`endif

    assign wr_en      = (state_q == S_WRITE) && !hold;
    assign bus.o_busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_MUL_P;
            S_MUL_P: state_d = S_MUL_I;
            S_MUL_I: state_d = S_SAT;
            S_SAT:   state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            last_q      <= CH_W'(N_CH - 1);
            ch_q        <= '0;
            err_q       <= '0;
            p_q         <= '0;
            int_new_q   <= '0;
            acc_q       <= '0;
            u_q         <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            bus.o_ack   <= '0;
            bus.o_valid <= 1'b0;
            bus.o_ch    <= '0;
            bus.o_u     <= '0;
            bus.o_sat   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bus.o_ack   <= '0;
            bus.o_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        ch_q      <= grant_ch;
                        err_q     <= err_arr[grant_ch];
                        last_q    <= grant_ch;
                        bus.o_ack <= N_CH'(1) << grant_ch;
                    end
                end
                S_MUL_P: begin
                    p_q       <= 64'(err_q) * KP64;
                    int_new_q <= int_sat;
                end
                S_MUL_I: begin
                    acc_q <= p_q + 64'(int_new_q) * TSKI64;
                end
                S_SAT: begin
                    sat_hi_q <= (acc_q > UMAX64);
                    sat_lo_q <= !(acc_q > UMAX64) && (acc_q < UMIN64);
                    if (acc_q > UMAX64) begin
                        u_q <= U_MAX;
                    end else if (acc_q < UMIN64) begin
                        u_q <= U_MIN;
                    end else begin
                        u_q <= acc_q[31:0];
                    end
                end
                S_WRITE: begin
                    bus.o_u     <= u_q;
                    bus.o_ch    <= ch_q;
                    bus.o_sat   <= sat_hi_q | sat_lo_q;
                    bus.o_valid <= 1'b1;
                end
                default: ;
            endcase
            // A clear landing on the write-back edge beats the write.
            for (int k = 0; k < N_CH; k++) begin
                if (bus.i_clr[k]) begin
                    integ_q[k] <= '0;
                end else if (wr_en && (ch_q == CH_W'(k))) begin
                    integ_q[k] <= int_new_q;
                end
            end
        end
    end
endmodule

// File: doc/pi_sched.md
# pi_sched

Time-multiplexed PI controller scheduler: shares one proportional/integral multiply-accumulate datapath among `N_CH` independent control loops. It arbitrates round-robin among requesting channels and sequences the datapath through a fixed 5-state FSM. It keeps one integrator per channel, saturates the output, and returns the result with a channel tag. It sits between the per-channel ADC/error blocks and the per-channel modulators.

## Interface

Parameters:

- `N_CH`, default 4: number of channels, 2..8. `CH_W` = clog2(`N_CH`) is derived locally.
- `KP`, default 1: proportional gain, signed integer.
- `TSKI`, default 0: integral gain pre-multiplied by Ts, signed integer.
- `U_MAX`, default 100: upper output clamp, signed 32-bit.
- `U_MIN`, default 0: lower output clamp, signed 32-bit, must be less than `U_MAX`.

Ports:

- `i_CLK`, in, 1: clock.
- `i_RST`, in, 1: synchronous, active-high reset.
- `i_req`, in, `N_CH`: per-channel compute request, level.
- `i_err`, in, 32*`N_CH`: packed signed errors. Channel k occupies bits [32k+31:32k].
- `i_clr`, in, `N_CH`: per-channel synchronous integrator clear.
- `o_ack`, out, `N_CH`: one-cycle grant pulse (one-hot).
- `o_valid`, out, 1: one-cycle result strobe.
- `o_ch`, out, `CH_W`: channel of the current result.
- `o_u`, out, 32: saturated signed control output.
- `o_sat`, out, 1: result was clamped.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation

FSM states are IDLE → MUL_P → MUL_I → SAT → WRITE → IDLE. There is no stalling.

- **IDLE**
  - If `i_req` is nonzero, grant the first requesting channel, searching from `last+1` modulo `N_CH`.
  - Latch `ch` and `err_q = i_err[ch]`; set `last = ch`.
  - Pulse `o_ack[ch]`.
  - Go to MUL_P.
- **MUL_P**
  - `p_q = err_q*KP`, computed at 64-bit signed.
  - `int_new = int[ch] + err_q`, saturating at ±(2^31−1); no wrap.
- **MUL_I**
  - `acc = p_q + int_new*TSKI`, computed at 64-bit signed.
- **SAT**
  - If `acc > U_MAX`: `u = U_MAX`, `sat_hi = 1`.
  - Else if `acc < U_MIN`: `u = U_MIN`, `sat_lo = 1`.
  - Else `u = acc[31:0]`.
- **WRITE**
  - Register `o_u`, `o_ch`, `o_sat = sat_hi|sat_lo`, and `o_valid = 1`.
  - Write the integrator back (see Configuration).
  - Return to IDLE.

Rules:

- Requests are level-sensitive and sampled only in IDLE.
  - A requester must drop `i_req` after seeing `o_ack`.
  - If `i_req` is still high on the next IDLE, it is treated as a new request.
- Changes to `i_err` after the grant have no effect on the current computation.
- `i_clr[k]` zeroes `int[k]` on the next edge, in any state.
  - If it coincides with the WRITE of channel k, the clear wins.
  - A clear of a channel that is currently in flight does not alter `int_new` already computed.
- `o_u`, `o_ch` and `o_sat` hold their last values until the next WRITE.

## Timing

- Reset values:
  - FSM = IDLE and `last = N_CH−1`, so channel 0 has priority first.
  - All `int[k] = 0`.
  - `o_ack = 0`, `o_valid = 0`, `o_ch = 0`, `o_u = 0`, `o_sat = 0`, `o_busy = 0`.
- Latency:
  - Grant at edge E0 puts `o_ack` high during cycle E0..E1.
  - `o_valid` is high during cycle E4..E5.
  - Request-to-result is 5 cycles; maximum throughput is one result per 5 cycles.
- `o_busy` is high from E0+ through E4+, and low in the cycle `o_valid` is high.
- The next grant can occur at E5, i.e. `o_ack` coincides with the next IDLE→MUL_P transition.
- Reset asserted mid-operation:
  - Aborts the sequence with no `o_valid` and no integrator write.
  - Applies all reset values on that edge.
- Starvation bound: a continuously requesting channel is granted within `N_CH` grants.

## Configuration

`PI_SCHED_AW_EN` selects conditional-integration anti-windup.

- **Defined:** in WRITE, `int[ch]` keeps its old value if (`sat_hi` and `err_q > 0`) or (`sat_lo` and `err_q < 0`); otherwise `int[ch] = int_new`.
- **Undefined:** `int[ch] = int_new` always.
- In both cases `o_u` is computed from `int_new`.

## Test plan

All scenarios use `N_CH=4`, `KP=2`, `TSKI=1`, `U_MAX=1000`, `U_MIN=−1000`.

1. After reset, `i_req=4'b0001`, ch0 err=10 → `o_ack=0001` one cycle; 5 cycles after the grant, `o_valid=1`, `o_ch=0`, `o_u=30`, `o_sat=0`. Repeating the request with err=10 gives `o_u=40`.
2. `i_req=4'b1111` held high, each requester dropping only its own bit on ack → grant order 0,1,2,3, acks exactly 5 cycles apart, four `o_valid` pulses tagged 0..3.
3. ch1 err=600, issued twice:
   - First result: `o_u=1000`, `o_sat=1`.
   - With `PI_SCHED_AW_EN`: `int1` stays 0 and the second result is 1000 with `int1` still 0.
   - Without it: `int1` is 600, then 1200.
4. ch2 err=−700 → `o_u=−1000`, `o_sat=1`. A following request with err=+5 → `o_sat=0`; `o_u=15` with the macro, −685 without.
5. Reset pulsed during MUL_I of ch3 → no `o_valid`, `o_busy=0` on the next cycle, all integrators 0; a subsequent ch3 err=10 request gives `o_u=30`.
6. `i_clr[0]` asserted in the WRITE cycle of a ch0 err=10 computation → `o_u=30` is reported, but `int0=0`; the next err=10 request gives `o_u=30`.
